// File: rtl/sap3_pkg.sv
// Shared SAP-3 definitions: register-file selects, ext encodings and the fetch state type.
package sap3_pkg;

  localparam logic [4:0] RF_SEL_NONE = 5'b00000;
  localparam logic [4:0] RF_SEL_PC   = 5'b11000;
  localparam logic [4:0] RF_SEL_W    = 5'b00110;
  localparam logic [4:0] RF_SEL_Z    = 5'b00111;

  localparam logic [1:0] EXT_NONE = 2'b00;
  localparam logic [1:0] EXT_INC  = 2'b01;
  localparam logic [1:0] EXT_DEC  = 2'b10;
  localparam logic [1:0] EXT_INC2 = 2'b11;

  typedef enum logic [2:0] {
    StIdle,
    StAddr,
    StRead,
    StInc,
    StWb,
    StDone
  } fetch_state_e;

  // Operand register written by the WB pass for operand index cnt (1 -> Z, 2 -> W).
  function automatic logic [4:0] operand_sel(input logic [1:0] cnt);
    return (cnt == 2'd1) ? RF_SEL_Z : RF_SEL_W;
  endfunction

endpackage

// File: rtl/op_len_decode.sv
// 8080 instruction length decode: opcode byte to total length in bytes (1..3).
module op_len_decode (
  input  logic [7:0] opcode_i,
  output logic [1:0] len_o
);

  always_comb begin
    len_o = 2'd1;
    casez (opcode_i)
      8'b00??0001,                           // LXI rp
      8'h22, 8'h2A, 8'h32, 8'h3A,            // SHLD/LHLD/STA/LDA
      8'hC3, 8'hCD,                          // JMP/CALL
      8'b11???010,                           // Jcc
      8'b11???100: len_o = 2'd3;             // Ccc
      8'b00???110,                           // MVI r
      8'hC6, 8'hCE, 8'hD6, 8'hDE,
      8'hE6, 8'hEE, 8'hF6, 8'hFE,
      8'hD3, 8'hDB: len_o = 2'd2;
      default: len_o = 2'd1;
    endcase
  end

endmodule

// File: rtl/fetch_seq.sv
// SAP-3 instruction-fetch sequencer: reads PC, fetches opcode plus operands into Z/W, bumps PC.
// Optional read timeout with sticky err is enabled by defining FETCH_TIMEOUT_EN.
module fetch_seq #(
  parameter int unsigned WAIT_MAX = 15,
  parameter int unsigned WAIT_W   = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [7:0]  mem_data,
  input  logic        mem_ready,
  output logic        mem_rd,
  output logic [15:0] mem_addr,
  input  logic [15:0] rf_rd_data,
  output logic [4:0]  rf_rd_sel,
  output logic [4:0]  rf_wr_sel,
  output logic [1:0]  rf_ext,
  output logic        rf_we,
  output logic [15:0] rf_wr_data,
  output logic [7:0]  opcode,
  output logic        busy,
  output logic        done,
  output logic        err
);
  import sap3_pkg::*;

  fetch_state_e state_q, state_d;
  logic [15:0]  addr_q, addr_d;
  logic [7:0]   byte_q, byte_d;
  logic [7:0]   opcode_q, opcode_d;
  logic [1:0]   cnt_q, cnt_d;
  logic [1:0]   len_q, len_d;
  logic [1:0]   dec_len;

  op_len_decode u_op_len_decode (
    .opcode_i (mem_data),
    .len_o    (dec_len)
  );

`ifdef FETCH_TIMEOUT_EN
  logic [WAIT_W-1:0] wait_q, wait_d;
  logic              err_q, err_d;
`else
  logic unused_cfg;
  assign unused_cfg = ^{WAIT_MAX, WAIT_W};
`endif

  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    byte_d     = byte_q;
    opcode_d   = opcode_q;
    cnt_d      = cnt_q;
    len_d      = len_q;
`ifdef FETCH_TIMEOUT_EN
    wait_d     = wait_q;
    err_d      = err_q;
`endif
    rf_rd_sel  = RF_SEL_NONE;
    rf_wr_sel  = RF_SEL_NONE;
    rf_ext     = EXT_NONE;
    rf_we      = 1'b0;
    rf_wr_data = 16'h0000;
    mem_rd     = 1'b0;
    done       = 1'b0;

    case (state_q)
      StIdle: begin
        if (start) begin
          cnt_d   = 2'd0;
`ifdef FETCH_TIMEOUT_EN
          err_d   = 1'b0;
`endif
          state_d = StAddr;
        end
      end

      StAddr: begin
        rf_rd_sel = RF_SEL_PC;
        addr_d    = rf_rd_data;
`ifdef FETCH_TIMEOUT_EN
        wait_d    = '0;
`endif
        state_d   = StRead;
      end

      StRead: begin
        mem_rd = 1'b1;
        if (mem_ready) begin
          byte_d = mem_data;
          if (cnt_q == 2'd0) begin
            opcode_d = mem_data;
            len_d    = dec_len;
          end
          state_d = StInc;
        end
`ifdef FETCH_TIMEOUT_EN
        else if (wait_q == WAIT_W'(WAIT_MAX - 1)) begin
          // Abandon the fetch; PC stays pointing at the byte that never arrived.
          err_d   = 1'b1;
          state_d = StIdle;
        end else begin
          wait_d = wait_q + 1'b1;
        end
`endif
      end

      StInc: begin
        // ext has priority over we in the register file, so we stays low here.
        rf_wr_sel = RF_SEL_PC;
        rf_ext    = EXT_INC;
        if (cnt_q != 2'd0) begin
          state_d = StWb;
        end else if (len_q == 2'd1) begin
          state_d = StDone;
        end else begin
          cnt_d   = 2'd1;
          state_d = StAddr;
        end
      end

      StWb: begin
        rf_we      = 1'b1;
        rf_wr_data = {8'h00, byte_q};
        rf_wr_sel  = operand_sel(cnt_q);
        if (cnt_q + 2'd1 == len_q) begin
          state_d = StDone;
        end else begin
          cnt_d   = cnt_q + 2'd1;
          state_d = StAddr;
        end
      end

      StDone: begin
        done    = 1'b1;
        state_d = StIdle;
      end

      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= StIdle;
      addr_q   <= 16'h0000;
      byte_q   <= 8'h00;
      opcode_q <= 8'h00;
      cnt_q    <= 2'd0;
      len_q    <= 2'd0;
    end else begin
      state_q  <= state_d;
      addr_q   <= addr_d;
      byte_q   <= byte_d;
      opcode_q <= opcode_d;
      cnt_q    <= cnt_d;
      len_q    <= len_d;
    end
  end

`ifdef FETCH_TIMEOUT_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wait_q <= '0;
      err_q  <= 1'b0;
    end else begin
      wait_q <= wait_d;
      err_q  <= err_d;
    end
  end

  assign err = err_q;
`else
  assign err = 1'b0;
`endif

  assign mem_addr = addr_q;
  assign opcode   = opcode_q;
  assign busy     = (state_q != StIdle);

endmodule
